// File: rtl/fetch_pc_pkg.sv
// Shared types for the fetch/PC stage: FSM state encoding and save-register selects.
// Pure definitions; no logic, no latency.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } pc_state_t;

  localparam logic [1:0] kPCSelNone = 2'b00;
  localparam logic [1:0] kPCSel1    = 2'b01;
  localparam logic [1:0] kPCSel2    = 2'b10;
  localparam logic [1:0] kPCSel3    = 2'b11;

endpackage

// File: rtl/pc_save_file.sv
// Three PC save registers; write on the clock edge, combinational read of the selected entry.
// Select 00 reads zero and never writes; a write is visible to a read on the following cycle.
module pc_save_file
  import fetch_pc_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            we_i,
  input  logic [1:0]      sel_i,
  input  logic [PC_W-1:0] wdat_i,
  output logic [PC_W-1:0] rdat_o
);

  logic [PC_W-1:0] reg1_q, reg2_q, reg3_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      reg1_q <= '0;
      reg2_q <= '0;
      reg3_q <= '0;
    end else if (we_i) begin
      case (sel_i)
        kPCSel1: reg1_q <= wdat_i;
        kPCSel2: reg2_q <= wdat_i;
        kPCSel3: reg3_q <= wdat_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdat_o = '0;
    case (sel_i)
      kPCSel1: rdat_o = reg1_q;
      kPCSel2: rdat_o = reg2_q;
      kPCSel3: rdat_o = reg3_q;
      default: rdat_o = '0;
    endcase
  end

endmodule

// File: rtl/fetch_pc.sv
// Program counter / fetch stage: IDLE/ARMED/RUN/DONE sequencer, next-PC mux, retired counter.
// All outputs registered; one instruction retired per RUN cycle, no input-to-output paths.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int SPC_OFFSET = 2,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             JumpEqual,
  input  logic             JumpNotEqual,
  input  logic             OffsetEn,
  input  logic [1:0]       PCRegSelect,
  input  logic             Equal,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  pc_state_t        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sel_active;
  logic             jump_taken;
  logic             save_en;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  save_dat;
  logic [PC_W-1:0]  save_rdat;
  logic [CNT_W-1:0] cnt_inc;

  // JumpEqual wins when both jump decodes are asserted.
  assign sel_active = (PCRegSelect != kPCSelNone);
  assign jump_taken = sel_active &&
                      (JumpEqual ? Equal : (JumpNotEqual && !Equal));
  assign save_en    = (state_q == RUN) && !Halt && sel_active &&
                      !JumpEqual && !JumpNotEqual;

  assign pc_inc   = pc_q + PC_W'(1);
  assign save_dat = OffsetEn ? (pc_q + PC_W'(SPC_OFFSET)) : pc_inc;
  assign cnt_inc  = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));

  pc_save_file #(
    .PC_W (PC_W)
  ) u_save (
    .clk_i   (Clk),
    .reset_i (Reset),
    .we_i    (save_en),
    .sel_i   (PCRegSelect),
    .wdat_i  (save_dat),
    .rdat_o  (save_rdat)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pc_d   = '0;
        done_d = 1'b0;
        if (Start) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        pc_d   = '0;
        cnt_d  = '0;
        done_d = 1'b0;
        if (!Start) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (Halt) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (jump_taken) begin
          pc_d = save_rdat;
        end else begin
          pc_d = pc_inc;
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (Start) begin
          state_d = ARMED;
          done_d  = 1'b0;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ProgCtr   = pc_q;
  assign Done      = done_q;
  assign InstCount = cnt_q;

endmodule
